// File: rtl/sc_et_pkg.sv
// Shared types and helpers for the early-termination SNG controller.
// Helpers work on MAXW-bit vectors; callers cast down to their width.
package sc_et_pkg;

  localparam int MAXW = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  localparam logic [MAXW-1:0] ONE = MAXW'(1);

  // Reverse the low w bits of v (van der Corput order of a counter).
  function automatic logic [MAXW-1:0] bit_rev(
    input logic [MAXW-1:0] v,
    input int              w
  );
    logic [MAXW-1:0] r;
    r = '0;
    for (int i = 0; i < MAXW; i++) begin
      if (i < w) begin
        r = r | (((v >> (w - 1 - i)) & ONE) << i);
      end
    end
    return r;
  endfunction

  // Bits [w-1:prec] set: those counter bits are bypassed.
  function automatic logic [MAXW-1:0] prec_mask(
    input int prec,
    input int w
  );
    logic [MAXW-1:0] m;
    m = '0;
    for (int i = 0; i < MAXW; i++) begin
      if (i >= prec && i < w) begin
        m = m | (ONE << i);
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/sc_cmp_sng.sv
// Comparator SNG core: one stream bit from x against the
// bit-reversed counter value.
module sc_cmp_sng
  import sc_et_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] cnt,
  output logic             b
);

  logic [WIDTH-1:0] rev;

  assign rev = WIDTH'(bit_rev(MAXW'(cnt), WIDTH));
  assign b   = (x > rev);

endmodule

// File: rtl/et_sng_ctrl.sv
// Early-termination SNG controller: runs 2^prec stream bits
// through an external bypass counter and returns the scaled ones count.
module et_sng_ctrl
  import sc_et_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int PW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [PW-1:0]    in_prec,
  input  logic             abort,
  output logic [WIDTH-1:0] bp,
  input  logic [WIDTH-1:0] cnt,
  input  logic             ovf,
  output logic             sbit,
  output logic             sbit_valid,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_result,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [PW-1:0]    prec_q, prec_d;
  logic [WIDTH:0]   ones_q, ones_d;
  logic             sbit_q, sbit_d;
  logic             sv_q, sv_d;
  logic             b;
  logic [PW-1:0]    prec_clamped;
  logic [PW-1:0]    shamt;

  sc_cmp_sng #(
    .WIDTH(WIDTH)
  ) u_cmp (
    .x  (x_q),
    .cnt(cnt),
    .b  (b)
  );

  always_comb begin
    prec_clamped = in_prec;
    if (in_prec == '0) begin
      prec_clamped = PW'(1);
    end else if (in_prec > PW'(WIDTH)) begin
      prec_clamped = PW'(WIDTH);
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    prec_d  = prec_q;
    ones_d  = ones_q;
    sbit_d  = sbit_q;
    sv_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d     = in_x;
          prec_d  = prec_clamped;
          ones_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // abort wins over a coincident final bit
        if (abort) begin
          ones_d  = '0;
          state_d = IDLE;
        end else begin
          ones_d = ones_q + {{WIDTH{1'b0}}, b};
          sbit_d = b;
          sv_d   = 1'b1;
          if (ovf) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      prec_q  <= PW'(1);
      ones_q  <= '0;
      sbit_q  <= 1'b0;
      sv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      prec_q  <= prec_d;
      ones_q  <= ones_d;
      sbit_q  <= sbit_d;
      sv_q    <= sv_d;
    end
  end

  // Outside RUN the counter is held at zero.
  assign bp = (state_q == RUN)
            ? WIDTH'(prec_mask(int'(prec_q), WIDTH))
            : '1;

  assign shamt      = PW'(WIDTH) - prec_q;
  assign out_result = ones_q << shamt;
  assign out_valid  = (state_q == DONE);
  assign in_ready   = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign sbit       = sbit_q;
  assign sbit_valid = sv_q;

endmodule

// File: tb/tb_et_sng_ctrl.sv
// Bench for et_sng_ctrl with a bypass counter alongside it;
// scoreboard queues filled by the driver, drained by a monitor.
module tb_et_sng_ctrl;

  localparam int W  = 8;
  localparam int PW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_x = '0;
  logic [PW-1:0] in_prec = '0;
  logic          abort = 1'b0;
  logic [W-1:0]  bp;
  logic [W-1:0]  cnt;
  logic          ovf;
  logic          sbit;
  logic          sbit_valid;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W:0]    out_result;
  logic          busy;

  always #5 clk = ~clk;

  // Bypass counter: bypassed bits read as 0 and propagate carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= (cnt + 1'b1) & ~bp;
  end
  assign ovf = &(cnt | bp);

  et_sng_ctrl #(.WIDTH(W), .PW(PW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_prec   (in_prec),
    .abort     (abort),
    .bp        (bp),
    .cnt       (cnt),
    .ovf       (ovf),
    .sbit      (sbit),
    .sbit_valid(sbit_valid),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .busy      (busy)
  );

  int tests = 0;
  int fails = 0;
  bit mon_en = 1'b1;
  bit          exp_bits[$];
  logic [W:0]  exp_res[$];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Reference model, straight from the stream definition.
  function automatic int clamp_prec(input int p);
    if (p == 0) return 1;
    if (p > W)  return W;
    return p;
  endfunction

  function automatic int rev_w(input int v);
    int r = 0;
    for (int i = 0; i < W; i++) r = r * 2 + ((v >> i) & 1);
    return r;
  endfunction

  function automatic int model_bit(input int x, input int i);
    return (x > rev_w(i)) ? 1 : 0;
  endfunction

  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      if (sbit_valid) begin
        if (exp_bits.size() == 0) check("sbit_extra", 1, 0);
        else check("sbit", {31'd0, sbit}, {31'd0, exp_bits.pop_front()});
      end
      if (out_valid && out_ready) begin
        if (exp_res.size() == 0) check("result_extra", 1, 0);
        else check("result", 32'(out_result), 32'(exp_res.pop_front()));
      end
    end
  end

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while (!in_ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("idle_timeout", 0, 1);
  endtask

  task automatic do_job(input int x, input int p,
                        input int abort_at, input bit stall);
    int pc  = clamp_prec(p);
    int n   = 1 << pc;
    int nb  = (abort_at >= 0) ? abort_at : n;
    int one = 0;
    int c   = 0;
    int expr;
    for (int i = 0; i < nb; i++) begin
      exp_bits.push_back(model_bit(x, i) != 0);
      one += model_bit(x, i);
    end
    expr = one * (1 << (W - pc));
    if (abort_at < 0) exp_res.push_back((W+1)'(expr));
    wait_idle();
    in_x     = W'(x);
    in_prec  = PW'(p);
    in_valid = 1'b1;
    out_ready = !stall;
    @(posedge clk);
    #1;
    // stray offers while busy must be ignored
    in_x = W'($urandom);
    in_valid = 1'($urandom);
    if (abort_at >= 0) begin
      repeat (abort_at) @(posedge clk);
      #1 abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check("abort_idle", {31'd0, in_ready}, 1);
      check("abort_bp", 32'(bp), 32'(8'hFF));
      check("abort_noval", {31'd0, out_valid}, 0);
    end else begin
      do begin
        @(negedge clk);
        c++;
      end while (!out_valid && c < 2000);
      in_valid = 1'b0;
      check("latency", c, n + 1);
      if (stall) begin
        for (int k = 0; k < 10; k++) begin
          check("stall_res", 32'(out_result), expr);
          check("stall_rdy", {31'd0, in_ready}, 0);
          check("stall_val", {31'd0, out_valid}, 1);
          abort = 1'($urandom);
          @(negedge clk);
        end
        abort = 1'b0;
        @(posedge clk);
        #1 out_ready = 1'b1;
      end else begin
        check("done_rdy", {31'd0, in_ready}, 0);
      end
    end
    wait_idle();
    check("drain", exp_bits.size() + exp_res.size(), 0);
  endtask

  task automatic check_reset_vals();
    check("rst_bp", 32'(bp), 32'(8'hFF));
    check("rst_sbit", {31'd0, sbit}, 0);
    check("rst_sv", {31'd0, sbit_valid}, 0);
    check("rst_oval", {31'd0, out_valid}, 0);
    check("rst_res", 32'(out_result), 0);
    check("rst_rdy", {31'd0, in_ready}, 1);
    check("rst_busy", {31'd0, busy}, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 check_reset_vals();
    rst_n = 1'b1;

    do_job(8'h80, 3, -1, 1'b0);
    do_job(8'h80, 8, -1, 1'b0);
    do_job(8'hFF, 4, -1, 1'b0);
    do_job(8'h00, 4, -1, 1'b0);
    do_job(8'h37, 0, -1, 1'b0);
    do_job(8'hA5, 12, -1, 1'b0);
    do_job(8'h5A, 6, 5, 1'b0);
    do_job(8'h80, 3, -1, 1'b0);
    do_job(8'hC3, 5, -1, 1'b1);

    // abort outside RUN does nothing
    @(posedge clk);
    #1 abort = 1'b1;
    repeat (2) @(posedge clk);
    #1 abort = 1'b0;
    check("idle_abort_busy", {31'd0, busy}, 0);
    check("idle_abort_rdy", {31'd0, in_ready}, 1);

    // reset in the middle of a job
    mon_en   = 1'b0;
    @(negedge clk);
    in_x     = 8'h9C;
    in_prec  = PW'(6);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_vals();
    exp_bits.delete();
    exp_res.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;
    do_job(8'h80, 3, -1, 1'b0);

    for (int j = 0; j < 40; j++) begin
      int x  = int'($urandom_range(255, 0));
      int p  = int'($urandom_range(15, 0));
      int pc = clamp_prec(p);
      int ab = -1;
      bit st = ($urandom_range(7, 0) == 0);
      if ($urandom_range(5, 0) == 0)
        ab = int'($urandom_range((1 << pc) - 1, 0));
      do_job(x, p, ab, st);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
